period_meas: RTL and testbench

PERIOD_MEAS -- requirements
Module: period_meas

---
 rtl/period_meas.sv | 173 +++++++++++++++++
 tb/tb_period_meas.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meas.sv
// -----------------------------------------------------------------------------
// period_meas
//   Measures the period of an asynchronous reference clock (ref_in) in units of
//   the local sampling clock and qualifies it as stable once STABLE_CNT
//   consecutive periods agree with their predecessor to within TOL cycles.
//
// Ports
//   clk           in   sampling clock, everything updates on its rising edge
//   RST           in   synchronous reset, active low (priority over PWRDWN)
//   PWRDWN        in   power-down, active high, behaves like reset
//   ref_in        in   asynchronous reference clock
//   ref_period    out  last measured period in clk cycles (0 = none)
//   period_stable out  ref_period is trusted
//   meas_valid    out  one-cycle pulse with every new measured ref_period
//   lock_lost     out  one-cycle pulse when period_stable drops (not on reset)
//   dbg_state     out  current FSM state (IDLE=0, ARM=1, MEASURE=2, STABLE=3)
//
// Handshake: there is no back-pressure; meas_valid is a pure strobe that is
// high for exactly the one cycle in which ref_period takes its new value.
// -----------------------------------------------------------------------------
module period_meas #(
  parameter int unsigned STABLE_CNT  = 4,
  parameter int unsigned TOL         = 1,
  parameter int unsigned TIMEOUT     = 65535,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        PWRDWN,
  input  logic        ref_in,
  output logic [31:0] ref_period,
  output logic        period_stable,
  output logic        meas_valid,
  output logic        lock_lost,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, MEASURE = 2'd2, STABLE = 2'd3} state_t;

  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);
  localparam logic [32:0] TOL_C     = 33'(TOL);
  localparam logic [7:0]  STABLE_C  = 8'(STABLE_CNT);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_dly_q, sync_dly_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [31:0]            ref_period_q, ref_period_d;
  logic [7:0]             mcnt_q, mcnt_d;
  logic                   have_prev_q, have_prev_d;
  logic                   period_stable_q, period_stable_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   lock_lost_q, lock_lost_d;

  logic                   clear;
  logic                   rise;
  logic                   timeout;
  logic [32:0]            diff;
  logic [32:0]            abs_diff;
  logic                   match;
  logic [7:0]             mcnt_inc;
  logic                   reach_stable;

  // Power-down is handled exactly like reset.
  assign clear = !RST || PWRDWN;

  assign sync_d     = {sync_q[SYNC_STAGES-2:0], ref_in};
  assign sync_dly_d = sync_q[SYNC_STAGES-1];
  assign rise       = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

  // An edge arriving together with the timeout is a measurement, not a loss.
  assign timeout = (cnt_q == TIMEOUT_C) && !rise;

  // 33-bit difference so the sign bit is available for the absolute value.
  assign diff     = {1'b0, cnt_q} - {1'b0, ref_period_q};
  assign abs_diff = diff[32] ? (~diff + 33'd1) : diff;
  assign match    = have_prev_q && (abs_diff <= TOL_C);

  assign mcnt_inc     = (mcnt_q >= STABLE_C) ? STABLE_C : (mcnt_q + 8'd1);
  assign reach_stable = match && (mcnt_inc == STABLE_C);

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q         <= IDLE;
      sync_q          <= '0;
      sync_dly_q      <= 1'b0;
      cnt_q           <= '0;
      ref_period_q    <= '0;
      mcnt_q          <= '0;
      have_prev_q     <= 1'b0;
      period_stable_q <= 1'b0;
      meas_valid_q    <= 1'b0;
      lock_lost_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync_q          <= sync_d;
      sync_dly_q      <= sync_dly_d;
      cnt_q           <= cnt_d;
      ref_period_q    <= ref_period_d;
      mcnt_q          <= mcnt_d;
      have_prev_q     <= have_prev_d;
      period_stable_q <= period_stable_d;
      meas_valid_q    <= meas_valid_d;
      lock_lost_q     <= lock_lost_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ARM;
      ARM:     if (rise) state_d = MEASURE;
      MEASURE: begin
        if (rise && reach_stable) state_d = STABLE;
        else if (timeout)         state_d = ARM;
      end
      STABLE: begin
        if (rise && !match) state_d = MEASURE;
        else if (timeout)   state_d = ARM;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    ref_period_d = ref_period_q;
    mcnt_d       = mcnt_q;
    have_prev_d  = have_prev_q;
    meas_valid_d = 1'b0;

    // Free-running period counter; saturates so a dead reference never wraps.
    if (state_q == IDLE)          cnt_d = '0;
    else if (rise)                cnt_d = 32'd1;
    else if (cnt_q < TIMEOUT_C)   cnt_d = cnt_q + 32'd1;
    else                          cnt_d = cnt_q;

    case (state_q)
      ARM: begin
        if (rise) begin
          mcnt_d      = '0;
          have_prev_d = 1'b0;
        end
      end
      MEASURE, STABLE: begin
        if (rise) begin
          ref_period_d = cnt_q;
          meas_valid_d = 1'b1;
          have_prev_d  = 1'b1;
          mcnt_d       = match ? mcnt_inc : 8'd0;
        end else if (timeout) begin
          ref_period_d = '0;
          mcnt_d       = '0;
          have_prev_d  = 1'b0;
        end
      end
      default: ;
    endcase

    // A zero period is never reported as stable.
    period_stable_d = (state_d == STABLE) && (ref_period_d != 32'd0);
    lock_lost_d     = (state_q == STABLE) && (state_d != STABLE);
  end

  assign ref_period    = ref_period_q;
  assign period_stable = period_stable_q;
  assign meas_valid    = meas_valid_q;
  assign lock_lost     = lock_lost_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_period_meas.sv
// -----------------------------------------------------------------------------
// tb_period_meas
//   Self-checking bench for period_meas (STABLE_CNT=4, TOL=1, TIMEOUT=100,
//   SYNC_STAGES=2). A timestamp-based reference model predicts every output
//   on every cycle; a table of single-edge rows and a few hand sequences check
//   the headline scenarios against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_period_meas;

  localparam int unsigned STABLE_N  = 4;
  localparam int unsigned TOL_N     = 1;
  localparam int unsigned TIMEOUT_N = 100;
  localparam int unsigned SYNC_N    = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARM    = 2'd1;
  localparam logic [1:0] ST_MEAS   = 2'd2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        RST;
  logic        PWRDWN;
  logic        ref_in;
  logic [31:0] ref_period;
  logic        period_stable;
  logic        meas_valid;
  logic        lock_lost;
  logic [1:0]  dbg_state;

  initial forever #5 clk = ~clk;

  period_meas #(
    .STABLE_CNT (STABLE_N),
    .TOL        (TOL_N),
    .TIMEOUT    (TIMEOUT_N),
    .SYNC_STAGES(SYNC_N)
  ) dut (
    .clk          (clk),
    .RST          (RST),
    .PWRDWN       (PWRDWN),
    .ref_in       (ref_in),
    .ref_period   (ref_period),
    .period_stable(period_stable),
    .meas_valid   (meas_valid),
    .lock_lost    (lock_lost),
    .dbg_state    (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int lost_cnt = 0;
  int valid_cnt = 0;
  logic [36:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Works with edge timestamps: a period is the distance between the update
  // cycles of two consecutive detected edges.
  bit          hist[$];
  int          m_phase = 0;  // 0 idle, 1 armed, 2 measuring
  bit          m_stable = 0;
  bit          m_have_prev = 0;
  int          m_run = 0;
  int unsigned m_period = 0;
  int unsigned m_last = 0;
  int unsigned m_n = 0;

  task automatic model_step();
    bit          in_rst;
    bit          rise;
    bit          valid;
    bit          lost;
    bit          ns;
    int          d;
    int unsigned p;
    logic [1:0]  st;
    in_rst = !RST || PWRDWN;
    hist.push_front(in_rst ? 1'b0 : ref_in);
    if (hist.size() > 8) void'(hist.pop_back());
    // A high sample at cycle k is acted on at cycle k+SYNC_N.
    rise  = (hist.size() > SYNC_N + 1) && hist[SYNC_N] && !hist[SYNC_N + 1];
    valid = 0;
    lost  = 0;
    if (in_rst) begin
      m_phase = 0; m_stable = 0; m_have_prev = 0; m_run = 0; m_period = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (rise) begin
        m_phase = 2; m_last = m_n; m_have_prev = 0; m_run = 0;
      end
    end else begin
      if (rise) begin
        p = m_n - m_last;
        m_last = m_n;
        valid = 1;
        d = int'(p) - int'(m_period);
        if (d < 0) d = -d;
        if (m_have_prev && d <= int'(TOL_N))
          m_run = (m_run < int'(STABLE_N)) ? m_run + 1 : m_run;
        else
          m_run = 0;
        m_period = p;
        m_have_prev = 1;
        ns = (m_run >= int'(STABLE_N));
        if (m_stable && !ns) lost = 1;
        m_stable = ns;
      end else if (m_n - m_last >= TIMEOUT_N) begin
        m_phase = 1; m_period = 0; m_have_prev = 0; m_run = 0;
        if (m_stable) lost = 1;
        m_stable = 0;
      end
    end
    m_n++;
    st = (m_phase == 0) ? 2'd0 : (m_phase == 1) ? 2'd1 : (m_stable ? 2'd3 : 2'd2);
    exp_q.push_back({m_period[31:0], m_stable, valid, lost, st});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- scoreboard ----------------
  initial forever begin : sb
    logic [36:0] e;
    logic [36:0] a;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {ref_period, period_stable, meas_valid, lock_lost, dbg_state};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL model t=%0t: got period=%0d stable=%0b valid=%0b lost=%0b state=%0d, required period=%0d stable=%0b valid=%0b lost=%0b state=%0d",
                 $time, a[36:5], a[4], a[3], a[2], a[1:0], e[36:5], e[4], e[3], e[2], e[1:0]);
      end
    end
  end

  // Pulse counters, sampled between edges so the main thread never races them.
  initial forever begin
    @(posedge clk);
    #1;
    if (lock_lost === 1'b1) lost_cnt++;
    if (meas_valid === 1'b1) valid_cnt++;
  end

  // ---------------- drivers ----------------
  // One rising edge followed by a gap: ref_in high for 2 cycles, low for gap-2.
  task automatic pulse(input int gap);
    for (int c = 0; c < gap; c++) begin
      @(negedge clk);
      ref_in = (c < 2);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      ref_in = 1'b0;
    end
  endtask

  // ---------------- vectors ----------------
  // Each row drives one edge, then waits `gap`; the edge measures the previous
  // row's gap. Expected values are taken at the end of the row.
  typedef struct {
    int          gap;
    logic [31:0] exp_period;
    logic        exp_stable;
    int          exp_lost;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int v0;
    int gap;
    int base;
    vecs[0]  = '{10, 0,  0, 0};  // first edge only arms
    vecs[1]  = '{10, 10, 0, 0};
    vecs[2]  = '{10, 10, 0, 0};
    vecs[3]  = '{10, 10, 0, 0};
    vecs[4]  = '{10, 10, 0, 0};
    vecs[5]  = '{10, 10, 1, 0};  // 5th measurement, 6th edge
    vecs[6]  = '{12, 10, 1, 0};
    vecs[7]  = '{10, 12, 0, 1};  // 12 measured: lock lost
    vecs[8]  = '{10, 10, 0, 1};  // |10-12| > TOL
    vecs[9]  = '{10, 10, 0, 1};
    vecs[10] = '{10, 10, 0, 1};
    vecs[11] = '{10, 10, 0, 1};
    vecs[12] = '{11, 10, 1, 1};  // relocked 5 edges after the 12
    vecs[13] = '{10, 11, 1, 1};  // jitter 10/11 stays stable
    vecs[14] = '{11, 10, 1, 1};
    vecs[15] = '{10, 11, 1, 1};
    vecs[16] = '{10, 10, 1, 1};
    vecs[17] = '{12, 10, 1, 1};
    vecs[18] = '{10, 12, 0, 2};  // difference of exactly TOL+1 breaks lock
    vecs[19] = '{10, 10, 0, 2};

    RST = 1'b0; PWRDWN = 1'b0; ref_in = 1'b0;
    idle_cycles(3);
    check("reset_period", ref_period, 32'd0);
    check("reset_stable", {31'd0, period_stable}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    RST = 1'b1;
    idle_cycles(3);
    check("armed_state", {30'd0, dbg_state}, {30'd0, ST_ARM});

    for (int i = 0; i < 20; i++) begin
      pulse(vecs[i].gap);
      check($sformatf("vec%0d_period", i), ref_period, vecs[i].exp_period);
      check($sformatf("vec%0d_stable", i), {31'd0, period_stable}, {31'd0, vecs[i].exp_stable});
      check($sformatf("vec%0d_lost", i), lost_cnt, vecs[i].exp_lost);
    end

    // Relock at 10, then stop the reference: timeout 100 updates after the edge.
    for (int i = 0; i < 5; i++) pulse(10);
    check("to_stable_before", {31'd0, period_stable}, 32'd1);
    idle_cycles(93);
    check("to_still_stable", {31'd0, period_stable}, 32'd1);
    idle_cycles(1);
    check("to_period", ref_period, 32'd0);
    check("to_stable", {31'd0, period_stable}, 32'd0);
    check("to_lost_pulse", {31'd0, lock_lost}, 32'd1);
    check("to_state", {30'd0, dbg_state}, {30'd0, ST_ARM});
    idle_cycles(1);
    check("to_lost_count", lost_cnt, 3);

    // One-cycle reset while stable.
    for (int i = 0; i < 6; i++) pulse(10);
    check("rst_pre_stable", {31'd0, period_stable}, 32'd1);
    @(negedge clk); RST = 1'b0;
    @(negedge clk); RST = 1'b1;
    check("rst_period", ref_period, 32'd0);
    check("rst_stable", {31'd0, period_stable}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    idle_cycles(2);
    check("rst_no_lost", lost_cnt, 3);
    for (int i = 0; i < 6; i++) pulse(10);
    check("rst_relock", {31'd0, period_stable}, 32'd1);
    check("rst_relock_period", ref_period, 32'd10);

    // Power-down while measuring.
    pulse(10); pulse(10);
    @(negedge clk); PWRDWN = 1'b1;
    idle_cycles(3);
    check("pd_period", ref_period, 32'd0);
    check("pd_stable", {31'd0, period_stable}, 32'd0);
    check("pd_valid", {31'd0, meas_valid}, 32'd0);
    check("pd_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    PWRDWN = 1'b0;
    idle_cycles(2);
    check("pd_no_lost", lost_cnt, 3);
    v0 = valid_cnt;
    pulse(10);
    check("pd_first_edge_no_valid", valid_cnt, v0);
    pulse(100);
    check("pd_second_edge_valid", valid_cnt, v0 + 1);

    // Edge exactly at the timeout count is a measurement; one cycle later is not.
    pulse(101);
    check("edge_at_timeout", ref_period, 32'd100);
    pulse(10);
    check("edge_after_timeout_period", ref_period, 32'd0);
    check("edge_after_timeout_state", {30'd0, dbg_state}, {30'd0, ST_MEAS});

    // Randomised periods, jitter, dropouts and resets; checked by the model.
    base = 10;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) base = $urandom_range(4, 40);
      if ($urandom_range(0, 9) == 0) gap = $urandom_range(95, 105);
      else gap = base + $urandom_range(0, 2);
      if ($urandom_range(0, 24) == 0) begin
        @(negedge clk); RST = 1'b0;
        @(negedge clk); RST = 1'b1;
      end
      pulse(gap);
    end
    idle_cycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
